// File: rtl/tcb_lite_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcb_lite_bridge_pkg
// Brief    : Shared types for the byte-stream to TCB-Lite manager bridge:
//            TCB-Lite configuration record, command opcodes, status codes
//            and bridge FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package tcb_lite_bridge_pkg;

    // Handshake configuration: response delay and request hold behaviour
    typedef struct packed {
        int unsigned DLY;
        logic        HLD;
    } tcb_lite_hsk_t;

    // Bus configuration: size mode, alignment, address and data widths
    typedef struct packed {
        logic        MOD;
        int unsigned ALW;
        int unsigned ADR;
        int unsigned DAT;
        int unsigned CHN;
    } tcb_lite_bus_t;

    typedef struct packed {
        tcb_lite_hsk_t HSK;
        tcb_lite_bus_t BUS;
    } tcb_lite_cfg_t;

    localparam tcb_lite_cfg_t TCB_LITE_CFG_DEF = '{
        HSK: '{DLY: 1, HLD: 1'b0},
        BUS: '{MOD: 1'b0, ALW: 0, ADR: 32, DAT: 32, CHN: 0}
    };

    // Command opcode carried in CMD[7:6]
    typedef enum logic [1:0] {
        OP_PING  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    // Status byte values returned as the first response byte
    localparam logic [7:0] STS_OK  = 8'h00;
    localparam logic [7:0] STS_ERR = 8'h01;
    localparam logic [7:0] STS_TMO = 8'h02;
    localparam logic [7:0] STS_SIZ = 8'hFD;
    localparam logic [7:0] STS_OP  = 8'hFE;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADR  = 3'd1,
        ST_WDT  = 3'd2,
        ST_REQ  = 3'd3,
        ST_RSP  = 3'd4,
        ST_STS  = 3'd5,
        ST_RDT  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tcb_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : tcb_lite_if
// Brief    : TCB-Lite bus interface (valid/ready handshake, request and
//            response records) with manager and subordinate modports.
// Revision : 1.0 - initial release
// ============================================================================
interface tcb_lite_if #(
    parameter tcb_lite_bridge_pkg::tcb_lite_cfg_t CFG = tcb_lite_bridge_pkg::TCB_LITE_CFG_DEF
) ();

    localparam int unsigned ADR_W = CFG.BUS.ADR;
    localparam int unsigned DAT_W = CFG.BUS.DAT;

    typedef struct packed {
        logic             ren;
        logic             wen;
        logic [ADR_W-1:0] adr;
        logic [1:0]       siz;
        logic [DAT_W-1:0] wdt;
        logic             lck;
        logic             ndn;
    } req_t;

    typedef struct packed {
        logic [DAT_W-1:0] rdt;
        logic             err;
    } rsp_t;

    logic vld;
    logic rdy;
    req_t req;
    rsp_t rsp;

    modport man (output vld, output req, input rdy, input rsp);
    modport sub (input vld, input req, output rdy, output rsp);

endinterface
`default_nettype wire

// File: rtl/tcb_lite_bridge_stream.sv
`default_nettype none
// ============================================================================
// Module   : tcb_lite_bridge_stream
// Brief    : Parses command packets from an 8-bit valid/ready stream, issues
//            one TCB-Lite transaction per command and streams back a status
//            byte (plus four read-data bytes on a successful read).
// Revision : 1.0 - initial release
// ============================================================================
module tcb_lite_bridge_stream
    import tcb_lite_bridge_pkg::*;
#(
    parameter tcb_lite_cfg_t CFG     = TCB_LITE_CFG_DEF,
    parameter int unsigned   TMO_CNT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    tcb_lite_if.man     man,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    output logic        rx_rdy,
    output logic        tx_vld,
    output logic [7:0]  tx_dat,
    input  logic        tx_rdy
);

    localparam int unsigned     c_adr_w    = CFG.BUS.ADR;
    localparam int unsigned     c_dat_w    = CFG.BUS.DAT;
    localparam int unsigned     c_tmo_w    = $clog2(TMO_CNT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CNT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    // Only log-size addressing and 0/1 response delay are supported
    if ((CFG.BUS.MOD != 1'b0) || (CFG.HSK.DLY > 1)) begin : g_cfg_err
        $error("tcb_lite_bridge_stream: unsupported CFG (BUS.MOD must be 0, HSK.DLY 0 or 1)");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_run;
    logic                 r_ren;
    logic                 r_wen;
    logic [1:0]           r_siz;
    logic [c_adr_w-1:0]   r_adr;
    logic [c_dat_w-1:0]   r_wdt;
    logic [c_dat_w-1:0]   r_rdt;
    logic [7:0]           r_sts;
    logic [1:0]           r_cnt;
    logic [c_tmo_w-1:0]   r_tmo;

    logic                 w_rx_hs;
    logic                 w_cmd_ld;
    logic                 w_ren_nxt;
    logic                 w_wen_nxt;
    logic                 w_adr_sh;
    logic                 w_wdt_sh;
    logic                 w_cnt_inc;
    logic                 w_tmo_inc;
    logic                 w_tmo_clr;
    logic                 w_sts_ld;
    logic [7:0]           w_sts_val;
    logic                 w_rsp_smp;
    logic [7:0]           w_tx_dat;

    // Receive side is only open while collecting a packet; r_run keeps it
    // closed until the first clock after reset.
    assign rx_rdy  = r_run & ((r_state == ST_IDLE) | (r_state == ST_ADR) | (r_state == ST_WDT));
    assign tx_vld  = (r_state == ST_STS) | (r_state == ST_RDT);
    assign tx_dat  = w_tx_dat;
    assign w_rx_hs = rx_vld & rx_rdy;

    assign man.vld     = (r_state == ST_REQ);
    assign man.req.ren = r_ren;
    assign man.req.wen = r_wen;
    assign man.req.adr = r_adr;
    assign man.req.siz = r_siz;
    assign man.req.wdt = r_wdt;
    assign man.req.lck = 1'b0;
    assign man.req.ndn = 1'b0;

    // Hold the receive side closed until the first clock edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ld    = 1'b0;
        w_ren_nxt   = 1'b0;
        w_wen_nxt   = 1'b0;
        w_adr_sh    = 1'b0;
        w_wdt_sh    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_tmo_inc   = 1'b0;
        w_tmo_clr   = 1'b0;
        w_sts_ld    = 1'b0;
        w_sts_val   = STS_OK;
        w_rsp_smp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_hs) begin
                    // Every command byte refreshes ren/wen so a ping or a
                    // rejected command never inherits a previous read.
                    w_cmd_ld = 1'b1;
                    case (op_t'(rx_dat[7:6]))
                        OP_PING: begin
                            w_sts_ld    = 1'b1;
                            w_sts_val   = STS_OK;
                            w_state_nxt = ST_STS;
                        end
                        OP_ILL: begin
                            w_sts_ld    = 1'b1;
                            w_sts_val   = STS_OP;
                            w_state_nxt = ST_STS;
                        end
                        default: begin
                            if (rx_dat[5:4] == 2'b11) begin
                                w_sts_ld    = 1'b1;
                                w_sts_val   = STS_SIZ;
                                w_state_nxt = ST_STS;
                            end else begin
                                w_ren_nxt   = (rx_dat[7:6] == OP_READ);
                                w_wen_nxt   = (rx_dat[7:6] == OP_WRITE);
                                w_state_nxt = ST_ADR;
                            end
                        end
                    endcase
                end
            end
            ST_ADR: begin
                if (w_rx_hs) begin
                    w_adr_sh  = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 2'd3) w_state_nxt = r_wen ? ST_WDT : ST_REQ;
                end
            end
            ST_WDT: begin
                if (w_rx_hs) begin
                    w_wdt_sh  = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 2'd3) w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (man.rdy) begin
                    w_tmo_clr = 1'b1;
                    if (CFG.HSK.DLY == 0) begin
                        w_rsp_smp   = 1'b1;
                        w_state_nxt = ST_STS;
                    end else begin
                        w_state_nxt = ST_RSP;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_tmo_clr   = 1'b1;
                    w_sts_ld    = 1'b1;
                    w_sts_val   = STS_TMO;
                    w_state_nxt = ST_STS;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_RSP: begin
                w_rsp_smp   = 1'b1;
                w_state_nxt = ST_STS;
            end
            ST_STS: begin
                if (tx_rdy) w_state_nxt = (r_ren && (r_sts == STS_OK)) ? ST_RDT : ST_IDLE;
            end
            ST_RDT: begin
                if (tx_rdy) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 2'd3) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Packet fields, byte counter, timeout counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ren <= 1'b0;
            r_wen <= 1'b0;
            r_siz <= 2'd0;
            r_adr <= '0;
            r_wdt <= '0;
            r_rdt <= '0;
            r_sts <= STS_OK;
            r_cnt <= 2'd0;
            r_tmo <= '0;
        end else begin
            if (w_cmd_ld) begin
                r_ren <= w_ren_nxt;
                r_wen <= w_wen_nxt;
                r_siz <= rx_dat[5:4];
                r_cnt <= 2'd0;
            end
            // Bytes arrive LSB-first, so shift in from the top
            if (w_adr_sh)  r_adr <= {rx_dat, r_adr[c_adr_w-1:8]};
            if (w_wdt_sh)  r_wdt <= {rx_dat, r_wdt[c_dat_w-1:8]};
            if (w_cnt_inc) r_cnt <= r_cnt + 2'd1;
            if (w_tmo_clr)      r_tmo <= '0;
            else if (w_tmo_inc) r_tmo <= r_tmo + c_tmo_one;
            if (w_sts_ld)       r_sts <= w_sts_val;
            else if (w_rsp_smp) r_sts <= man.rsp.err ? STS_ERR : STS_OK;
            if (w_rsp_smp) r_rdt <= man.rsp.rdt;
        end
    end

    // Response byte select: status first, then read data LSB-first
    always_comb begin
        w_tx_dat = 8'h00;
        case (r_state)
            ST_STS:  w_tx_dat = r_sts;
            ST_RDT:  w_tx_dat = r_rdt[{r_cnt, 3'b000} +: 8];
            default: w_tx_dat = 8'h00;
        endcase
    end

endmodule
`default_nettype wire
